writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL be clocked by a single clock and reset synchronously, active-high.
REQ-002 Parameter DATA_WIDTH, default 32, is the datapath width; legal values are 32 and 64.
REQ-003 Parameter CNT_WIDTH, default 64, is the width of the retire counter.
REQ-004 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ValidM_i  in  1  M-stage instruction valid
- RegWriteM_i  in  1  M-stage register-write enable
- ResultSrcM_i  in  3  result select
- Funct3M_i  in  3  load size/sign encoding
- ALUResultM_i  in  DATA_WIDTH  ALU result / load address
- ReadDataM_i  in  DATA_WIDTH  raw aligned memory word
- PCPlus4M_i  in  DATA_WIDTH  PC+4
- ImmExtM_i  in  DATA_WIDTH  extended immediate (LUI)
- RdM_i  in  5  destination register
- StallW_i  in  1  hold W register
- FlushW_i  in  1  insert bubble into W
- ResultW_o  out  DATA_WIDTH  write-back data
- RdW_o  out  5  write-back destination
- RegWriteW_o  out  1  qualified register-file write enable
- ValidW_o  out  1  W-stage valid
- LoadMisalignW_o  out  1  misaligned load in W
- InstRetW_o  out  CNT_WIDTH  retired-instruction count

Function
REQ-005 The M/W register SHALL capture all M-stage inputs on the rising clk edge when StallW_i=0 and FlushW_i=0; latency from M inputs to W outputs is 1 cycle.
REQ-006 With StallW_i=1 and FlushW_i=0, the W register SHALL hold its contents.
REQ-007 FlushW_i=1 SHALL take priority over StallW_i and load a bubble: valid=0, regwrite=0, rd=0, all other fields 0.
REQ-008 ResultW_o SHALL be combinational from the registered fields: ResultSrc 000 selects ALU, 001 selects formatted load, 010 selects PC+4, 011 selects ImmExt, all others select 0.
REQ-009 The byte offset SHALL be ALUResult[log2(DATA_WIDTH/8)-1:0].
REQ-010 Load formatting SHALL follow Funct3:
- 000 LB sign-extend
- 001 LH sign-extend
- 010 LW sign-extend
- 011 LD, legal only when DATA_WIDTH=64
- 100 LBU zero-extend
- 101 LHU zero-extend
- 110 LWU, legal only when DATA_WIDTH=64
- Each selects the lane at the byte offset.
REQ-011 An illegal Funct3 for the configured width SHALL yield a load result of 0.
REQ-012 LoadMisalignW_o SHALL be 1 when ValidW=1, ResultSrc=001, and the offset is not a multiple of the access size; it is 0 otherwise.
REQ-013 RegWriteW_o SHALL equal registered RegWrite AND ValidW AND (RdW!=0) AND NOT LoadMisalignW_o.
REQ-014 RdW_o SHALL be the registered Rd unchanged.
REQ-015 InstRetW_o SHALL increment by 1 on each edge where ValidW_o=1, LoadMisalignW_o=0, and (StallW_i=0 or FlushW_i=1), so that a held instruction counts exactly once.
REQ-016 InstRetW_o SHALL wrap modulo 2^CNT_WIDTH.
REQ-017 When rst and any other input are asserted in the same cycle, rst SHALL win.

Reset
REQ-018 On rst=1 at the clk edge, all W register fields and InstRetW_o SHALL become 0; consequently ResultW_o=0, RdW_o=0, RegWriteW_o=0, ValidW_o=0, and LoadMisalignW_o=0 in the following cycle.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction without counting it.

Structure
REQ-020 Package wb_pkg SHALL hold:
- the ResultSrc enum (RES_ALU, RES_LOAD, RES_PC4, RES_IMM)
- the load Funct3 constants
- the default CNT_WIDTH
REQ-021 Load formatting SHALL be a combinational sub-module named load_extend, parametrised by DATA_WIDTH.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LB, ReadData=0x8000_7F80, ALU=0x1001 -> next cycle ResultW=0x0000_007F; with ALU=0x1000 -> 0xFFFF_FF80; LBU at 0x1000 -> 0x0000_0080.
- LH at ALU=0x1003 -> LoadMisalignW_o=1, RegWriteW_o=0, InstRetW_o unchanged.
- Rd=0, RegWrite=1, ALU=0x55 -> RegWriteW_o=0, ResultW=0x55.
- Valid ALU instruction, StallW_i=1 for 3 cycles, then 0 -> W outputs constant for 4 cycles, InstRetW_o +1 total.
- StallW_i=1 and FlushW_i=1 together -> bubble next cycle (ValidW_o=0), held instruction counted once.
- rst asserted with InstRetW_o=0xFFFF_FFFF_FFFF_FFFF -> 0; separately, a counter preloaded via 2^64-1 retirements wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

  // Write-back result source select
  typedef enum logic [2:0] {
    RES_ALU  = 3'b000,
    RES_LOAD = 3'b001,
    RES_PC4  = 3'b010,
    RES_IMM  = 3'b011
  } res_src_e;

  // Load size/sign encodings carried in Funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int WB_CNT_WIDTH = 64;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load lane selection and sign/zero extension, plus misalignment detect.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                       funct3_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  offset_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DATA_WIDTH-1:0]            result_o,
  output logic                             misalign_o
);

  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ext;
  logic [2:0]            size_mask;
  logic [2:0]            off3;

  // Shift the addressed byte down to bit 0, then extend per access size.
  // Illegal encodings leave ext=0 and size_mask=0 (never misaligned).
  always_comb begin
    lane      = data_i >> {offset_i, 3'b000};
    off3      = 3'(offset_i);
    ext       = '0;
    size_mask = 3'b000;
    case (funct3_i)
      F3_LB:  ext = DATA_WIDTH'($signed(lane[7:0]));
      F3_LBU: ext = DATA_WIDTH'(lane[7:0]);
      F3_LH: begin
        ext       = DATA_WIDTH'($signed(lane[15:0]));
        size_mask = 3'b001;
      end
      F3_LHU: begin
        ext       = DATA_WIDTH'(lane[15:0]);
        size_mask = 3'b001;
      end
      F3_LW: begin
        ext       = DATA_WIDTH'($signed(lane[31:0]));
        size_mask = 3'b011;
      end
      F3_LWU: begin
        if (DATA_WIDTH == 64) begin
          ext       = DATA_WIDTH'(lane[31:0]);
          size_mask = 3'b011;
        end
      end
      F3_LD: begin
        if (DATA_WIDTH == 64) begin
          ext       = lane;
          size_mask = 3'b111;
        end
      end
      default: ext = '0;
    endcase
    result_o   = ext;
    misalign_o = (off3 & size_mask) != 3'b000;
  end

endmodule

// File: rtl/writeback_stage.sv
// M/W pipeline register, result mux, write qualification and retire counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = WB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM_i,
  input  logic                  RegWriteM_i,
  input  logic [2:0]            ResultSrcM_i,
  input  logic [2:0]            Funct3M_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] ReadDataM_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4M_i,
  input  logic [DATA_WIDTH-1:0] ImmExtM_i,
  input  logic [4:0]            RdM_i,
  input  logic                  StallW_i,
  input  logic                  FlushW_i,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [4:0]            RdW_o,
  output logic                  RegWriteW_o,
  output logic                  ValidW_o,
  output logic                  LoadMisalignW_o,
  output logic [CNT_WIDTH-1:0]  InstRetW_o
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);

  logic                  valid_q, valid_d;
  logic                  regwrite_q, regwrite_d;
  logic [2:0]            src_q, src_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;

  logic [DATA_WIDTH-1:0] load_result;
  logic                  load_misalign;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .funct3_i  (funct3_q),
    .offset_i  (alu_q[OFF_W-1:0]),
    .data_i    (rdata_q),
    .result_o  (load_result),
    .misalign_o(load_misalign)
  );

  // Next W contents: flush beats stall; the retire count advances when the
  // instruction in W leaves it (not held), so a stalled one counts once.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    funct3_d   = funct3_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    if (FlushW_i) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      src_d      = '0;
      funct3_d   = '0;
      alu_d      = '0;
      rdata_d    = '0;
      pc4_d      = '0;
      imm_d      = '0;
      rd_d       = '0;
    end else if (!StallW_i) begin
      valid_d    = ValidM_i;
      regwrite_d = RegWriteM_i;
      src_d      = ResultSrcM_i;
      funct3_d   = Funct3M_i;
      alu_d      = ALUResultM_i;
      rdata_d    = ReadDataM_i;
      pc4_d      = PCPlus4M_i;
      imm_d      = ImmExtM_i;
      rd_d       = RdM_i;
    end
    instret_d = instret_q;
    if (ValidW_o && !LoadMisalignW_o && (!StallW_i || FlushW_i)) begin
      instret_d = instret_q + CNT_WIDTH'(1);
    end
  end

  // W register and retire counter with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      funct3_q   <= funct3_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      instret_q  <= instret_d;
    end
  end

  // Result select from the registered fields
  always_comb begin
    ResultW_o = '0;
    case (src_q)
      RES_ALU:  ResultW_o = alu_q;
      RES_LOAD: ResultW_o = load_result;
      RES_PC4:  ResultW_o = pc4_q;
      RES_IMM:  ResultW_o = imm_q;
      default:  ResultW_o = '0;
    endcase
  end

  assign LoadMisalignW_o = valid_q && (src_q == RES_LOAD) && load_misalign;
  assign RegWriteW_o     = regwrite_q && valid_q && (rd_q != 5'd0) && !LoadMisalignW_o;
  assign RdW_o           = rd_q;
  assign ValidW_o        = valid_q;
  assign InstRetW_o      = instret_q;

endmodule
